// File: rtl/mul_pkg.sv
// Shared types and widths for the RV32M iterative multiplier.
package mul_pkg;

    localparam int unsigned XLEN_P = 32;
    localparam int unsigned PROD_W = 2 * XLEN_P;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        OpMul    = 2'b00,
        OpMulh   = 2'b01,
        OpMulhsu = 2'b10,
        OpMulhu  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } mul_state_e;

    function automatic logic op_rs1_signed(input mul_op_e op);
        return (op == OpMulh) || (op == OpMulhsu);
    endfunction

    function automatic logic op_rs2_signed(input mul_op_e op);
        return (op == OpMulh);
    endfunction

endpackage

// File: rtl/ksa_adder.sv
// Kogge-Stone parallel-prefix adder with carry-in and carry-out.
module ksa_adder #(
    parameter int unsigned data_size = 64
) (
    input  logic [data_size-1:0] i_a,
    input  logic [data_size-1:0] i_b,
    input  logic                 i_cin,
    output logic [data_size-1:0] o_sum,
    output logic                 o_cout
);

    localparam int unsigned LVL = $clog2(data_size);

    logic [data_size-1:0] w_p0;
    logic [data_size-1:0] w_g;
    logic [data_size-1:0] w_p;
    logic [data_size-1:0] w_gn;
    logic [data_size-1:0] w_pn;
    logic [data_size:0]   w_c;

    always_comb begin
        w_p0 = i_a ^ i_b;
        w_g  = i_a & i_b;
        w_p  = w_p0;
        w_gn = '0;
        w_pn = '0;
        // After level l, (w_g, w_p)[i] cover the span [i : i - 2^(l+1) + 1].
        for (int l = 0; l < int'(LVL); l++) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int i = (1 << l); i < int'(data_size); i++) begin
                w_gn[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                w_pn[i] = w_p[i] & w_p[i - (1 << l)];
            end
            w_g = w_gn;
            w_p = w_pn;
        end
        w_c[0] = i_cin;
        for (int i = 0; i < int'(data_size); i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & i_cin);
        end
    end

    assign o_sum  = w_p0 ^ w_c[data_size-1:0];
    assign o_cout = w_c[data_size];

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Define MUL_EARLY_OUT_EN to leave CALC once the remaining multiplier bits are zero.
module mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_P
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned PW = 2 * XLEN;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    mul_state_e        r_state;
    mul_op_e           r_op;
    logic [PW-1:0]     r_mc;
    logic [XLEN-1:0]   r_mp;
    logic              r_neg;
    logic [PW-1:0]     r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;

    mul_state_e        w_state;
    mul_op_e           w_op;
    logic [PW-1:0]     w_mc;
    logic [XLEN-1:0]   w_mp;
    logic              w_neg;
    logic [PW-1:0]     w_acc;
    logic [CNT_W-1:0]  w_cnt;
    logic [XLEN-1:0]   w_result;

    mul_op_e           w_in_op;
    logic              w_rs1_neg;
    logic              w_rs2_neg;
    logic [XLEN-1:0]   w_rs1_mag;
    logic [XLEN-1:0]   w_rs2_mag;
    logic              w_last;
    logic [PW-1:0]     w_add_a;
    logic [PW-1:0]     w_add_b;
    logic              w_add_cin;
    logic [PW-1:0]     w_sum;
    logic              w_unused_cout;
    logic [PW-1:0]     w_fixed;

    // Magnitudes: 0x80000000 negates to itself, read as unsigned 2^31.
    assign w_in_op   = mul_op_e'(i_op);
    assign w_rs1_neg = op_rs1_signed(w_in_op) & i_rs1[XLEN-1];
    assign w_rs2_neg = op_rs2_signed(w_in_op) & i_rs2[XLEN-1];
    assign w_rs1_mag = w_rs1_neg ? -i_rs1 : i_rs1;
    assign w_rs2_mag = w_rs2_neg ? -i_rs2 : i_rs2;

`ifdef MUL_EARLY_OUT_EN
    assign w_last = (r_cnt == CNT_LAST) || (r_mp[XLEN-1:1] == '0);
`else
    assign w_last = (r_cnt == CNT_LAST);
`endif

    // FIX reuses the adder for two's complement: ~acc + 0 + 1.
    always_comb begin
        w_add_a   = r_acc;
        w_add_b   = r_mc;
        w_add_cin = 1'b0;
        if (r_state == StFix) begin
            w_add_a   = ~r_acc;
            w_add_b   = '0;
            w_add_cin = 1'b1;
        end
    end

    ksa_adder #(
        .data_size (PW)
    ) u_ksa_adder (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_unused_cout)
    );

    assign w_fixed = r_neg ? w_sum : r_acc;

    always_comb begin
        w_state  = r_state;
        w_op     = r_op;
        w_mc     = r_mc;
        w_mp     = r_mp;
        w_neg    = r_neg;
        w_acc    = r_acc;
        w_cnt    = r_cnt;
        w_result = r_result;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_op    = w_in_op;
                    w_mc    = {{XLEN{1'b0}}, w_rs1_mag};
                    w_mp    = w_rs2_mag;
                    w_neg   = w_rs1_neg ^ w_rs2_neg;
                    w_acc   = '0;
                    w_cnt   = '0;
                    w_state = StCalc;
                end
            end
            StCalc: begin
                if (r_mp[0]) begin
                    w_acc = w_sum;
                end
                w_mc  = r_mc << 1;
                w_mp  = r_mp >> 1;
                w_cnt = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_state = StFix;
                end
            end
            StFix: begin
                w_acc    = w_fixed;
                w_result = (r_op == OpMul) ? w_fixed[XLEN-1:0] : w_fixed[PW-1:XLEN];
                w_state  = StDone;
            end
            StDone: begin
                w_state = StIdle;
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_op     <= OpMul;
            r_mc     <= '0;
            r_mp     <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state;
            r_op     <= w_op;
            r_mc     <= w_mc;
            r_mp     <= w_mp;
            r_neg    <= w_neg;
            r_acc    <= w_acc;
            r_cnt    <= w_cnt;
            r_result <= w_result;
        end
    end

    assign o_ready  = (r_state == StIdle);
    assign o_busy   = (r_state == StCalc) || (r_state == StFix);
    assign o_done   = (r_state == StDone);
    assign o_result = r_result;

endmodule

// File: tb/tb_mul_unit.sv
// Directed and randomized checks of mul_unit against a 64-bit arithmetic reference.
module tb_mul_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    mul_unit #(
        .XLEN (32)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_op     (op),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .o_ready  (ready),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] p;
        sa = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        sb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = sa * sb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] m;
        int hi;
        m  = (o == 2'b01 && b[31]) ? -b : b;
        hi = 0;
        for (int i = 0; i < 32; i++) if (m[i]) hi = i + 1;
        if (hi == 0) hi = 1;
`ifdef MUL_EARLY_OUT_EN
        return hi + 1;
`else
        return 33;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    // Caller is positioned #1 after an edge; returns #1 after the edge following done.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res);
        int n;
        int lat;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_ready_low"}, {31'b0, ready}, 32'd0);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!done && lat < 100);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat(o, b)));
        chk({tag, "_result"}, result, model(o, a, b));
        res = result;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] corners [5];
        int lat;
        int seen;
        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;

        rst = 1'b1; start = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;

        do_op("mul_7x6", 2'b00, 32'd7, 32'd6, res);
        chk("mul_7x6_lit", res, 32'h0000_002A);
        do_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, res);
        chk("mulh_min_lit", res, 32'h4000_0000);
        do_op("mulh_m1x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, res);
        chk("mulh_m1x2_lit", res, 32'hFFFF_FFFF);
        do_op("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res);
        chk("mulhu_max_lit", res, 32'hFFFF_FFFE);
        do_op("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res);
        chk("mul_max_lit", res, 32'h0000_0001);
        do_op("mulhsu_a", 2'b10, 32'hFFFF_FFFF, 32'h8000_0000, res);
        chk("mulhsu_a_lit", res, 32'hFFFF_FFFF);
        do_op("mulhsu_b", 2'b10, 32'h0000_0003, 32'hFFFF_FFFF, res);
        chk("mulhsu_b_lit", res, 32'h0000_0002);
        do_op("eo_rs2_1", 2'b00, 32'd5, 32'd1, res);
        chk("eo_rs2_1_lit", res, 32'd5);
        do_op("eo_rs2_100", 2'b00, 32'd3, 32'h0000_0100, res);
        do_op("eo_rs2_0", 2'b11, 32'h1234_5678, 32'd0, res);

        // A start pulsed mid-CALC must be ignored.
        start = 1'b1; op = 2'b00; rs1 = 32'd7; rs2 = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b11; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("ign_latency", 32'(lat), 32'(exp_lat(2'b00, 32'd6)));
        chk("ign_result", result, 32'h0000_002A);
        repeat (2) @(posedge clk);
        #1;
        chk("ign_no_restart", {31'b0, busy}, 32'd0);

        // Reset at CALC edge 10 aborts the request.
        start = 1'b1; op = 2'b11; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", {31'b0, ready}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        for (int k = 0; k < 40; k++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            do_op($sformatf("rnd%0d", k), ro, ra, rb, res);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
